fp_div_seq: RTL and testbench

//  Sequential IEEE-754 binary floating-point divider, parametrised in exponent/mantissa width.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_div_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point divider.
// Holds the FSM state encoding, operand classes, flag bit positions and format helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } fp_div_state_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  localparam int FLG_W         = 5;
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_INVALID   = 4;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set (formats up to 64 bits).
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one IEEE-754 word into sign/exponent/mantissa and operand class.
// Denormal inputs (exponent zero) are classified as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] word_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W-1:0]     mant_o,
  output fp_class_t            cls_o
);

  assign sign_o = word_i[EXP_W+MAN_W];
  assign exp_o  = word_i[EXP_W+MAN_W-1:MAN_W];
  assign mant_o = word_i[MAN_W-1:0];

  always_comb begin
    if (exp_o == '0)     cls_o = FP_ZERO;
    else if (&exp_o)     cls_o = (mant_o == '0) ? FP_INF : FP_NAN;
    else                 cls_o = FP_NORM;
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential radix-2 restoring IEEE-754 divider, one quotient bit per clock, round-to-nearest-even.
// Define FP_DIV_FLAGS_EN to add the out_flags port and the exception flag registers.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [FLG_W-1:0]     out_flags
`endif
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 3;
  localparam int CNT_W = $clog2(N + 1);
  localparam int EW    = EXP_W + 2;
  localparam int RW    = MAN_W + 2;
  localparam int BIAS  = fp_bias(EXP_W);
  localparam logic [63:0]          QNAN64   = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN64[W-1:0];
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  fp_class_t        a_cls, b_cls;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .word_i(in_a), .sign_o(a_sign), .exp_o(a_exp), .mant_o(a_man), .cls_o(a_cls)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .word_i(in_b), .sign_o(b_sign), .exp_o(b_exp), .mant_o(b_man), .cls_o(b_cls)
  );

  fp_div_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [MAN_W:0]       dvs_q, dvs_d;
  logic [N-1:0]         quo_q, quo_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         result_q, result_d;
`ifdef FP_DIV_FLAGS_EN
  logic [FLG_W-1:0]     flags_q, flags_d, spec_flags, rnd_flags;
`endif

  logic         accept, q_sign, spec_hit;
  logic [W-1:0] spec_res;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign q_sign   = a_sign ^ b_sign;

  // Special operands resolve in one step; priority order matters (NaN/invalid first).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    spec_hit = 1'b1;
    spec_res = {q_sign, {(W-1){1'b0}}};
`ifdef FP_DIV_FLAGS_EN
    spec_flags = '0;
`endif
    if (a_cls == FP_NAN || b_cls == FP_NAN ||
        (a_cls == FP_ZERO && b_cls == FP_ZERO) || (a_cls == FP_INF && b_cls == FP_INF)) begin
      spec_res = QNAN;
`ifdef FP_DIV_FLAGS_EN
      spec_flags[FLG_INVALID] = 1'b1;
`endif
    end else if (b_cls == FP_ZERO) begin
      spec_res = {q_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      spec_flags[FLG_DIVZERO] = 1'b1;
`endif
    end else if (a_cls == FP_INF) begin
      spec_res = {q_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_cls == FP_ZERO || b_cls == FP_INF) begin
      spec_res = {q_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [MAN_W-1:0]     rnd_man_pre, rnd_man;
  logic                 rnd_guard, rnd_sticky, rnd_up, rnd_carry;
  logic signed [EW-1:0] rnd_exp_pre, rnd_exp;
  logic [W-1:0]         rnd_res;

  // Normalise on the integer quotient bit, then round to nearest even.
  always_comb begin
    if (quo_q[N-1]) begin
      rnd_man_pre = quo_q[N-2:2];
      rnd_guard   = quo_q[1];
      rnd_sticky  = quo_q[0] | (rem_q != '0);
      rnd_exp_pre = exp_q;
    end else begin
      rnd_man_pre = quo_q[N-3:1];
      rnd_guard   = quo_q[0];
      rnd_sticky  = (rem_q != '0);
      rnd_exp_pre = exp_q - EW'(1);
    end
    rnd_up               = rnd_guard & (rnd_sticky | rnd_man_pre[0]);
    {rnd_carry, rnd_man} = {1'b0, rnd_man_pre} + {{MAN_W{1'b0}}, rnd_up};
    rnd_exp              = rnd_exp_pre + {{(EW-1){1'b0}}, rnd_carry};
    rnd_res              = {sign_q, rnd_exp[EXP_W-1:0], rnd_man};
`ifdef FP_DIV_FLAGS_EN
    rnd_flags              = '0;
    rnd_flags[FLG_INEXACT] = rnd_guard | rnd_sticky;
`endif
    if (rnd_exp >= EXP_MAX) begin
      rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      rnd_flags[FLG_OVERFLOW] = 1'b1;
      rnd_flags[FLG_INEXACT]  = 1'b1;
`endif
    end else if (rnd_exp <= EXP_ZERO) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      rnd_flags[FLG_UNDERFLOW] = 1'b1;
      rnd_flags[FLG_INEXACT]   = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef FP_DIV_FLAGS_EN
    flags_d     = flags_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept && spec_hit) begin
          result_d    = spec_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`ifdef FP_DIV_FLAGS_EN
          flags_d     = spec_flags;
`endif
        end else if (accept) begin
          rem_d   = {1'b0, 1'b1, a_man};
          dvs_d   = {1'b1, b_man};
          quo_d   = '0;
          cnt_d   = '0;
          sign_d  = q_sign;
          exp_d   = EW'(a_exp) - EW'(b_exp) + EW'(BIAS);
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rem_q >= {1'b0, dvs_q}) begin
          quo_d = {quo_q[N-2:0], 1'b1};
          rem_d = (rem_q - {1'b0, dvs_q}) << 1;
        end else begin
          quo_d = {quo_q[N-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        if (cnt_q == CNT_W'(N - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d    = rnd_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
`ifdef FP_DIV_FLAGS_EN
        flags_d     = rnd_flags;
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef FP_DIV_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef FP_DIV_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
`ifdef FP_DIV_FLAGS_EN
  assign out_flags  = flags_q;
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq (binary32): exact-integer reference model, scoreboard
// with cycle-accurate latency, random backpressure, directed special cases and mid-op reset.
module tb_fp_div_seq;

  localparam int LAT_DIV  = 23 + 5;
  localparam int LAT_SPEC = 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  out_flags;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  exp_t sb[$];

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef FP_DIV_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: exact integer quotient of the significands, then IEEE round-to-nearest-even.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e;
    logic s, a_z, b_z, a_i, b_i, a_n, b_n, guard, sticky;
    longint unsigned na, nb, q, rm, mant;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    s   = a[31] ^ b[31];
    a_z = (ea == 0);   b_z = (eb == 0);
    a_i = (ea == 255) && (a[22:0] == 0);
    b_i = (eb == 255) && (b[22:0] == 0);
    a_n = (ea == 255) && (a[22:0] != 0);
    b_n = (eb == 255) && (b[22:0] != 0);
    r.flg = '0; r.lat = LAT_SPEC; r.due = 0;
    if (a_n || b_n || (a_z && b_z) || (a_i && b_i)) begin
      r.res = 32'h7FC0_0000; r.flg = 5'b10000;
    end else if (b_z) begin
      r.res = {s, 8'hFF, 23'h0}; r.flg = 5'b01000;
    end else if (a_i) begin
      r.res = {s, 8'hFF, 23'h0};
    end else if (a_z || b_i) begin
      r.res = {s, 31'h0};
    end else begin
      r.lat = LAT_DIV;
      na = 64'(a[22:0]) | 64'h80_0000;
      nb = 64'(b[22:0]) | 64'h80_0000;
      e  = ea - eb + 127;
      if (na >= nb) begin
        q = (na << 24) / nb;  rm = (na << 24) % nb;
      end else begin
        q = (na << 25) / nb;  rm = (na << 25) % nb;  e = e - 1;
      end
      guard  = q[0];
      sticky = (rm != 0);
      mant   = q >> 1;
      if (guard && (sticky || mant[0])) mant = mant + 1;
      if (mant[24]) e = e + 1;
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0}; r.flg = 5'b00101;
      end else if (e <= 0) begin
        r.res = {s, 31'h0}; r.flg = 5'b00011;
      end else begin
        r.res = {s, 8'(e), mant[22:0]}; r.flg = {4'b0, guard | sticky};
      end
    end
    return r;
  endfunction

  // Compare process: checks handshake, latency, result and stability every cycle.
  always @(negedge clk) begin
    exp_t m;
    if (rst) begin
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
      sb.delete();
    end else begin
      check("in_ready", 32'(in_ready), 32'(sb.size() == 0));
      if (sb.size() == 0) begin
        check("out_valid_idle", 32'(out_valid), 32'd0);
      end else if (cyc < sb[0].due) begin
        check("out_valid_early", 32'(out_valid), 32'd0);
      end else begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_result", out_result, sb[0].res);
`ifdef FP_DIV_FLAGS_EN
        check("out_flags", 32'(out_flags), 32'(sb[0].flg));
`endif
        if (out_valid && out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        m = model(in_a, in_b);
        m.due = cyc + m.lat;
        sb.push_back(m);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin timeout("accept_wait"); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    drive(a, b);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin @(posedge clk); n++; end
    if (sb.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0]  e;
    logic [22:0] m;
    int k;
    k = $urandom_range(0, 11);
    m = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) m = '0; end
      2:       e = 8'($urandom_range(1, 12));
      3:       e = 8'($urandom_range(243, 254));
      4:       begin e = 8'($urandom_range(100, 150)); m = 23'h7F_FFFF ^ 23'($urandom_range(0, 3)); end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  logic [31:0] dir_a [15] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F7FFFFF,
                              32'h00800000, 32'h7FC00001, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                              32'h00000000, 32'h40000000, 32'hC0C00000, 32'h00000005, 32'h3F800000};
  logic [31:0] dir_b [15] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3F000000,
                              32'h40000000, 32'h3F800000, 32'hFF800001, 32'hFF800000, 32'h40000000,
                              32'hC0000000, 32'h7F800000, 32'h40000000, 32'h3F800000, 32'h00000005};

  initial begin
    exp_t p;
    // Hand-computed pins on the reference model itself.
    p = model(32'h40C00000, 32'h40000000);
    check("pin_6div2", p.res, 32'h40400000);  check("pin_6div2_flg", 32'(p.flg), 32'h0);
    check("pin_6div2_lat", 32'(p.lat), 32'd28);
    p = model(32'h3F800000, 32'h40400000);
    check("pin_1div3", p.res, 32'h3EAAAAAB);  check("pin_1div3_flg", 32'(p.flg), 32'h01);
    p = model(32'h3F800000, 32'h00000000);
    check("pin_divzero", p.res, 32'h7F800000); check("pin_divzero_flg", 32'(p.flg), 32'h08);
    p = model(32'h00000000, 32'h00000000);
    check("pin_0div0", p.res, 32'h7FC00000);  check("pin_0div0_flg", 32'(p.flg), 32'h10);
    check("pin_0div0_lat", 32'(p.lat), 32'd1);
    p = model(32'h7F7FFFFF, 32'h3F000000);
    check("pin_ovf", p.res, 32'h7F800000);    check("pin_ovf_flg", 32'(p.flg), 32'h05);
    p = model(32'h00800000, 32'h40000000);
    check("pin_unf", p.res, 32'h00000000);    check("pin_unf_flg", 32'(p.flg), 32'h03);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
`ifdef FP_DIV_FLAGS_EN
    check("rst_out_flags", 32'(out_flags), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed operands, back-to-back.
    for (int i = 0; i < 15; i++) send(dir_a[i], dir_b[i]);
    drain();

    // Backpressure: result held, second op waits until the handshake.
    ready_mode = 2;
    send(32'h40C00000, 32'h40000000);
    drive(32'h3F800000, 32'h40400000);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) timeout("bp_out_valid");
    end
    repeat (10) @(negedge clk);
    ready_mode = 0;
    wait_accept();
    drain();

    // Reset at iteration 10, then a clean operation.
    send(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h40C00000, 32'h40000000);
    drain();

    // Randomized operands with random consumer backpressure and issue gaps.
    ready_mode = 1;
    for (int i = 0; i < 250; i++) begin
      send(rand_word(), rand_word());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    ready_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
